// File: rtl/counter_pkg.sv
// Shared types and defaults for the synchronous down counter.
package counter_pkg;
    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage

// File: rtl/sync_down_counter_if.sv
// Command/status bundle between a controller and the down counter.
interface sync_down_counter_if
    import counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             auto_reload;
    logic [WIDTH-1:0] Q;
    logic             tc;
    logic             busy;

    modport master (output clear, load, load_val, en, auto_reload,
                    input  Q, tc, busy);
    modport slave  (input  clear, load, load_val, en, auto_reload,
                    output Q, tc, busy);
endinterface

// File: rtl/down_count_reg.sv
// Count register: clear > load > decrement, saturating at zero.
module down_count_reg
    import counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_q,
    output logic             o_is_one,
    output logic             o_is_zero
);
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                  r_q <= '0;
        else if (i_clear)              r_q <= '0;
        else if (i_load)               r_q <= i_load_val;
        else if (i_dec && r_q != '0)   r_q <= r_q - WIDTH'(1);
    end

    assign o_q       = r_q;
    assign o_is_one  = (r_q == WIDTH'(1));
    assign o_is_zero = (r_q == '0);
endmodule

// File: rtl/sync_down_counter.sv
// Loadable down counter with one-shot/auto-reload modes and a registered tc pulse.
module sync_down_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                clk,
    input  logic                reset_n,
    sync_down_counter_if.slave  bus
);
    state_e           r_state, w_next;
    logic [WIDTH-1:0] r_reload;
    logic             r_tc, r_busy;
    logic             w_tc_nxt, w_ld, w_dec;
    logic [WIDTH-1:0] w_ld_val;
    logic [WIDTH-1:0] w_q;
    logic             w_is_one, w_is_zero;

    down_count_reg #(.WIDTH(WIDTH)) u_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_clear    (bus.clear),
        .i_load     (w_ld),
        .i_load_val (w_ld_val),
        .i_dec      (w_dec),
        .o_q        (w_q),
        .o_is_one   (w_is_one),
        .o_is_zero  (w_is_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_reload <= '0;
            r_tc     <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_tc    <= w_tc_nxt;
            r_busy  <= (w_next == RUN);
            if (!bus.clear && bus.load) r_reload <= bus.load_val;
        end
    end

    // Zero in RUN only occurs after a tc under auto_reload; the reload
    // goes through the register's load port so no tc is raised.
    always_comb begin
        w_next   = r_state;
        w_tc_nxt = 1'b0;
        w_ld     = 1'b0;
        w_ld_val = bus.load_val;
        w_dec    = 1'b0;
        if (bus.clear) begin
            w_next = IDLE;
        end else if (bus.load) begin
            w_ld   = 1'b1;
            w_next = (bus.load_val != '0) ? RUN : IDLE;
        end else if (r_state == RUN && bus.en) begin
            if (w_is_zero) begin
                if (bus.auto_reload) begin
                    w_ld     = 1'b1;
                    w_ld_val = r_reload;
                end else begin
                    w_next = DONE;
                end
            end else begin
                w_dec = 1'b1;
                if (w_is_one) begin
                    w_tc_nxt = 1'b1;
                    if (!bus.auto_reload) w_next = DONE;
                end
            end
        end
    end

    assign bus.Q    = w_q;
    assign bus.tc   = r_tc;
    assign bus.busy = r_busy;
endmodule

// File: tb/tb_sync_down_counter.sv
// Directed bench for sync_down_counter with an expected-value scoreboard queue.
module tb_sync_down_counter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [5:0] exp_q[$];

    sync_down_counter_if #(.WIDTH(4)) bus ();

    sync_down_counter #(.WIDTH(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s Q/tc/busy got=%0d/%0b/%0b exp=%0d/%0b/%0b",
                   tag, obs[5:2], obs[1], obs[0], expv[5:2], expv[1], expv[0]);
        end
    endtask

    // Drive one cycle of commands, push expectation, compare after the edge.
    task automatic cyc(input string tag, input logic cl, input logic ld,
                       input logic [3:0] lv, input logic e, input logic ar,
                       input logic [3:0] eq, input logic etc, input logic eb);
        logic [5:0] expv;
        bus.clear = cl; bus.load = ld; bus.load_val = lv;
        bus.en = e; bus.auto_reload = ar;
        exp_q.push_back({eq, etc, eb});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            expv = exp_q.pop_front();
            chk(tag, {bus.Q, bus.tc, bus.busy}, expv);
        end
    endtask

    initial begin
        bus.clear = 0; bus.load = 0; bus.load_val = 0; bus.en = 0; bus.auto_reload = 0;
        #2;
        chk("reset", {bus.Q, bus.tc, bus.busy}, 6'b0);
        @(negedge clk); reset_n = 1'b1;

        // reset mid-run
        cyc("rm_load9", 0, 1, 9, 0, 0, 9, 0, 1);
        cyc("rm_en1",   0, 0, 0, 1, 0, 8, 0, 1);
        cyc("rm_en2",   0, 0, 0, 1, 0, 7, 0, 1);
        cyc("rm_en3",   0, 0, 0, 1, 0, 6, 0, 1);
        #2 reset_n = 1'b0;
        #1 chk("rm_async", {bus.Q, bus.tc, bus.busy}, 6'b0);
        @(negedge clk); reset_n = 1'b1;
        cyc("rm_en_after", 0, 0, 0, 1, 0, 0, 0, 0);

        // one-shot
        cyc("os_load3", 0, 1, 3, 0, 0, 3, 0, 1);
        cyc("os_2",     0, 0, 0, 1, 0, 2, 0, 1);
        cyc("os_1",     0, 0, 0, 1, 0, 1, 0, 1);
        cyc("os_0_tc",  0, 0, 0, 1, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) cyc("os_hold", 0, 0, 0, 1, 0, 0, 0, 0);

        // auto-reload
        cyc("ar_load2", 0, 1, 2, 0, 1, 2, 0, 1);
        for (int p = 0; p < 3; p++) begin
            cyc("ar_1",  0, 0, 0, 1, 1, 1, 0, 1);
            cyc("ar_0",  0, 0, 0, 1, 1, 0, 1, 1);
            cyc("ar_rl", 0, 0, 0, 1, 1, 2, 0, 1);
        end

        // auto-reload dropped while sitting at zero: stop, no tc
        cyc("arz_load1", 0, 1, 1, 0, 1, 1, 0, 1);
        cyc("arz_tc",    0, 0, 0, 1, 1, 0, 1, 1);
        cyc("arz_stop",  0, 0, 0, 1, 0, 0, 0, 0);
        cyc("arz_hold",  0, 0, 0, 1, 1, 0, 0, 0);

        // enable gaps
        cyc("eg_load5", 0, 1, 5, 0, 0, 5, 0, 1);
        cyc("eg_e1",    0, 0, 0, 1, 0, 4, 0, 1);
        cyc("eg_e0",    0, 0, 0, 0, 0, 4, 0, 1);
        cyc("eg_e1b",   0, 0, 0, 1, 0, 3, 0, 1);
        cyc("eg_e0b",   0, 0, 0, 0, 0, 3, 0, 1);
        cyc("eg_e1c",   0, 0, 0, 1, 0, 2, 0, 1);
        cyc("eg_e1d",   0, 0, 0, 1, 0, 1, 0, 1);

        // load beats a terminal decrement, no tc
        cyc("pr_load7",    0, 1, 7, 1, 0, 7, 0, 1);
        cyc("pr_clr_load", 1, 1, 9, 1, 0, 0, 0, 0);
        cyc("pr_idle_en",  0, 0, 0, 1, 0, 0, 0, 0);
        cyc("pr_load4",    0, 1, 4, 0, 0, 4, 0, 1);
        cyc("pr_load0",    0, 1, 0, 1, 0, 0, 0, 0);
        cyc("pr_load0_en", 0, 0, 0, 1, 0, 0, 0, 0);

        // width boundary: 15 down to 0 with no wrap
        cyc("wb_load15", 0, 1, 15, 0, 0, 15, 0, 1);
        for (int v = 14; v >= 1; v--) cyc("wb_dec", 0, 0, 0, 1, 0, 4'(v), 0, 1);
        cyc("wb_tc", 0, 0, 0, 1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc("wb_nowrap", 0, 0, 0, 1, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
